// File: rtl/maj_sweep_ctrl.sv
// maj_sweep_ctrl: built-in self-test sequencer for a 3-input majority evaluator.
//
// Operation:
//   - Steps {a,b,c} through all eight input combinations.
//   - Holds each vector for DWELL cycles, then samples y_in for one cycle.
//   - Compares y_in with an internal golden majority and counts mismatches.
//
// Optional build macro:
//   MAJ_SWEEP_FIRST_FAIL_EN adds the fail_idx port, which latches the first
//   mismatching vector index of each sweep.
module maj_sweep_ctrl #(
  parameter int DWELL = 4,  // cycles each vector is held before sampling (1..255)
  parameter int CNT_W = 8   // dwell counter width, must hold DWELL-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
  ,
  output logic [2:0] fail_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [2:0]       vec_reg,   vec_next;
  logic [3:0]       err_reg,   err_next;
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
  logic [2:0]       fail_reg,  fail_next;
`endif

  logic gold;
  logic mismatch;

  // Golden majority of the vector currently applied, and its comparison
  // against the evaluator output.
  assign gold     = (vec_reg[2] & vec_reg[1]) | (vec_reg[1] & vec_reg[0]) |
                    (vec_reg[0] & vec_reg[2]);
  assign mismatch = (y_in != gold);

  // State register; reset returns to IDLE with every output-feeding register cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      vec_reg   <= '0;
      err_reg   <= '0;
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
      fail_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      vec_reg   <= vec_next;
      err_reg   <= err_next;
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
      fail_reg  <= fail_next;
`endif
    end
  end

  // Next-state and datapath logic for the sweep.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    vec_next   = vec_reg;
    err_next   = err_reg;
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
    fail_next  = fail_reg;
`endif
    case (state_reg)
      S_IDLE, S_DONE: begin
        // A start is honoured only when no sweep is in progress.
        if (start) begin
          state_next = S_DRIVE;
          cnt_next   = RELOAD;
          vec_next   = 3'd0;
          err_next   = 4'd0;
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
          fail_next  = 3'd0;
`endif
        end
      end
      S_DRIVE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          // Eight vectors at most, so the 4-bit count cannot overflow.
          err_next = err_reg + 4'd1;
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
          // Only the first mismatch of a sweep is recorded.
          if (err_reg == 4'd0) begin
            fail_next = vec_reg;
          end
`endif
        end
        if (vec_reg == 3'd7) begin
          // The index stays at 7; DONE is entered instead of wrapping.
          state_next = S_DONE;
        end else begin
          vec_next   = vec_reg + 3'd1;
          cnt_next   = RELOAD;
          state_next = S_DRIVE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from registers only, so y_in and start have no
  // combinational path to any output.
  always_comb begin
    a_out   = vec_reg[2];
    b_out   = vec_reg[1];
    c_out   = vec_reg[0];
    vec_idx = vec_reg;
    err_cnt = err_reg;
    busy    = (state_reg == S_DRIVE) || (state_reg == S_CHECK);
    done    = (state_reg == S_DONE);
    pass    = (state_reg == S_DONE) && (err_reg == 4'd0);
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
    fail_idx = fail_reg;
`endif
  end

endmodule

// File: tb/tb_maj_sweep_ctrl.sv
// tb_maj_sweep_ctrl: scoreboard bench for maj_sweep_ctrl.
//
// Instances and models:
//   - Instance 0 uses DWELL=4; instance 1 uses DWELL=1.
//   - Each instance's y_in comes from a selectable evaluator model: correct,
//     stuck at 0, or the faulty a&b evaluator.
//
// Scoreboard:
//   - The expected sweep result is pushed when start is driven.
//   - It is popped and compared when done rises.
//
// Optional build macro:
//   MAJ_SWEEP_FIRST_FAIL_EN enables the fail_idx checks.
module tb_maj_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start   [2];
  logic       y_in    [2];
  logic       a_out   [2];
  logic       b_out   [2];
  logic       c_out   [2];
  logic [2:0] vec_idx [2];
  logic       busy    [2];
  logic       done    [2];
  logic       pass    [2];
  logic [3:0] err_cnt [2];
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
  logic [2:0] fail_idx[2];
`endif

  int mode [2];

  typedef struct packed {
    logic [3:0] err;
    logic       pass;
    logic [2:0] fail;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  maj_sweep_ctrl #(.DWELL(4), .CNT_W(8)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start[0]),
    .y_in    (y_in[0]),
    .a_out   (a_out[0]),
    .b_out   (b_out[0]),
    .c_out   (c_out[0]),
    .vec_idx (vec_idx[0]),
    .busy    (busy[0]),
    .done    (done[0]),
    .pass    (pass[0]),
    .err_cnt (err_cnt[0])
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
    ,
    .fail_idx(fail_idx[0])
`endif
  );

  maj_sweep_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start[1]),
    .y_in    (y_in[1]),
    .a_out   (a_out[1]),
    .b_out   (b_out[1]),
    .c_out   (c_out[1]),
    .vec_idx (vec_idx[1]),
    .busy    (busy[1]),
    .done    (done[1]),
    .pass    (pass[1]),
    .err_cnt (err_cnt[1])
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
    ,
    .fail_idx(fail_idx[1])
`endif
  );

  // Evaluator models: 0 = correct majority, 1 = output stuck at 0, 2 = a&b only
  function automatic logic y_model(input int md, input logic [2:0] v);
    case (md)
      0:       return ($countones(v) >= 2);
      1:       return 1'b0;
      default: return v[2] & v[1];
    endcase
  endfunction

  always_comb y_in[0] = y_model(mode[0], {a_out[0], b_out[0], c_out[0]});
  always_comb y_in[1] = y_model(mode[1], {a_out[1], b_out[1], c_out[1]});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one sweep on instance s with evaluator model md.
  //   mid_at >= 0 : pulses start again while vec_idx == mid_at
  //   rst_at >= 0 : asserts rst for one cycle on the first DRIVE cycle of
  //                 vector rst_at, which aborts the sweep
  task automatic run_sweep(input int s, input int md, input int mid_at, input int rst_at);
    int   dw, n, busy_n, e_err, e_fail;
    bit   pulsed, in_rst, aborted;
    exp_t e, got;

    dw     = (s == 0) ? 4 : 1;
    e_err  = 0;
    e_fail = 0;
    for (int v = 0; v < 8; v++) begin
      if (y_model(md, 3'(v)) != ($countones(3'(v)) >= 2)) begin
        if (e_err == 0) e_fail = v;
        e_err++;
      end
    end
    e.err  = 4'(e_err);
    e.pass = (e_err == 0);
    e.fail = 3'(e_fail);
    exp_q.push_back(e);

    mode[s]  = md;
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    chk("busy_at_start", busy[s], 1);
    chk("vec_at_start", vec_idx[s], 0);
    chk("err_cleared", err_cnt[s], 0);
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
    chk("fail_cleared", fail_idx[s], 0);
`endif

    n       = 0;
    busy_n  = 1;
    pulsed  = 0;
    in_rst  = 0;
    aborted = 0;
    forever begin
      if (mid_at >= 0 && !pulsed && vec_idx[s] == 3'(mid_at)) begin
        start[s] = 1'b1;
        pulsed   = 1;
      end
      if (rst_at >= 0 && vec_idx[s] == 3'(rst_at) && busy[s]) begin
        rst    = 1'b1;
        in_rst = 1;
      end
      @(posedge clk); #1;
      n++;
      start[s] = 1'b0;
      if (in_rst) begin
        rst = 1'b0;
        chk("rst_busy", busy[s], 0);
        chk("rst_done", done[s], 0);
        chk("rst_pass", pass[s], 0);
        chk("rst_vec", vec_idx[s], 0);
        chk("rst_abc", {a_out[s], b_out[s], c_out[s]}, 0);
        chk("rst_err", err_cnt[s], 0);
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
        chk("rst_fail", fail_idx[s], 0);
`endif
        void'(exp_q.pop_back());
        aborted = 1;
        break;
      end
      if (done[s]) break;
      if (busy[s]) busy_n++;
      chk("vec_step", vec_idx[s], n / (dw + 1));
      chk("abc_eq_vec", {a_out[s], b_out[s], c_out[s]}, vec_idx[s]);
      if (n > 2000) begin
        chk("done_timeout", 0, 1);
        aborted = 1;
        void'(exp_q.pop_back());
        break;
      end
    end

    if (!aborted) begin
      chk("sweep_len", n, 8 * (dw + 1));
      chk("busy_cycles", busy_n, 8 * (dw + 1));
      got = exp_q.pop_front();
      chk("err_cnt", err_cnt[s], got.err);
      chk("pass", pass[s], got.pass);
      chk("vec_final", vec_idx[s], 7);
      chk("busy_at_done", busy[s], 0);
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
      if (got.err != 0) chk("fail_idx", fail_idx[s], got.fail);
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", done[s], 1);
      chk("vec_held", vec_idx[s], 7);
      $display("sweep inst=%0d mode=%0d cycles=%0d err_cnt=%0d pass=%0d",
               s, md, n, err_cnt[s], pass[s]);
    end else begin
      $display("sweep inst=%0d mode=%0d aborted after %0d cycles", s, md, n);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    mode[0]  = 0;
    mode[1]  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("reset_busy", busy[s], 0);
      chk("reset_done", done[s], 0);
      chk("reset_pass", pass[s], 0);
      chk("reset_vec", vec_idx[s], 0);
      chk("reset_err", err_cnt[s], 0);
`ifdef MAJ_SWEEP_FIRST_FAIL_EN
      chk("reset_fail", fail_idx[s], 0);
`endif
    end

    run_sweep(0, 0, -1, -1);  // correct evaluator
    run_sweep(0, 1, -1, -1);  // y_in stuck at 0
    run_sweep(0, 2, -1, -1);  // faulty a&b evaluator
    run_sweep(0, 2,  2, -1);  // start pulsed mid-sweep is ignored
    run_sweep(0, 0, -1, -1);  // restart after DONE clears err_cnt
    run_sweep(0, 0, -1,  5);  // reset at vector 5 aborts the sweep
    run_sweep(0, 0, -1, -1);  // clean sweep after reset
    run_sweep(1, 0, -1, -1);  // DWELL=1, correct evaluator
    run_sweep(1, 1, -1, -1);  // DWELL=1, stuck at 0

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
